// File: rtl/mspeckey_dec_iter.sv
// Iterative mini-SPECKEY decryption core: one inverse ARX round per clock,
// round keys consumed from the highest index down to rk[0].
module mspeckey_dec_iter #(
    parameter int NR  = 4,
    parameter int KAW = (NR > 1) ? $clog2(NR) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           key_we,
    input  logic [KAW-1:0] key_idx,
    input  logic [15:0]    key_data,
    output logic           key_err,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [15:0]    in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [15:0]    out_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_nxt;
    logic [15:0]    r_s;
    logic [15:0]    r_out;
    logic [KAW-1:0] r_cnt;
    logic           r_kerr;
    logic [15:0]    r_rk [NR];

    logic           w_acc;
    logic           w_kok;
    logic [15:0]    w_src;
    logic [15:0]    w_key;
    logic [15:0]    w_f;

    // Key XOR, then undo the forward rotate/add/xor of one round.
    function automatic logic [15:0] inv_round(input logic [15:0] s,
                                              input logic [15:0] k);
        logic [15:0] t;
        logic [7:0]  t1;
        logic [7:0]  lo;
        logic [7:0]  d;
        t  = s ^ k;
        t1 = t[15:8] ^ t[7:0];
        lo = {t1[1:0], t1[7:2]};
        d  = t[15:8] - lo;
        return {d[0], d[7:1], lo};
    endfunction

    always_comb begin
        w_nxt = r_state;
        w_acc = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_acc = 1'b1;
                    w_nxt = (NR == 1) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == '0)
                    w_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready)
                    w_nxt = S_IDLE;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    assign w_src = w_acc ? in_data : r_s;
    assign w_key = w_acc ? r_rk[NR-1] : r_rk[r_cnt];
    assign w_f   = inv_round(w_src, w_key);
    assign w_kok = (r_state == S_IDLE) && (32'(key_idx) < NR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_s     <= '0;
            r_out   <= '0;
            r_cnt   <= '0;
            r_kerr  <= 1'b0;
            for (int i = 0; i < NR; i++)
                r_rk[i] <= '0;
        end else begin
            r_state <= w_nxt;
            r_kerr  <= key_we && !w_kok;
            if (w_acc || r_state == S_RUN)
                r_s <= w_f;
            if (w_acc)
                r_cnt <= KAW'(NR - 2);
            else if (r_state == S_RUN)
                r_cnt <= r_cnt - 1'b1;
            // Result register only moves on the transition into DONE.
            if (w_nxt == S_DONE && r_state != S_DONE)
                r_out <= w_f;
            if (key_we && w_kok)
                r_rk[key_idx] <= key_data;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_data  = r_out;
    assign key_err   = r_kerr;

endmodule

// File: tb/tb_mspeckey_dec_iter.sv
// Directed/table bench for mspeckey_dec_iter with NR=1 and NR=4 instances.
module tb_mspeckey_dec_iter;

    logic        clk;
    logic        rst;

    logic        key_we1, key_err1, in_valid1, in_ready1;
    logic        out_valid1, out_ready1;
    logic [0:0]  key_idx1;
    logic [15:0] key_data1, in_data1, out_data1;

    logic        key_we4, key_err4, in_valid4, in_ready4;
    logic        out_valid4, out_ready4;
    logic [1:0]  key_idx4;
    logic [15:0] key_data4, in_data4, out_data4;

    int n_cmp = 0;
    int n_err = 0;

    mspeckey_dec_iter #(.NR(1)) u1 (
        .clk(clk), .rst(rst),
        .key_we(key_we1), .key_idx(key_idx1), .key_data(key_data1),
        .key_err(key_err1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1)
    );

    mspeckey_dec_iter #(.NR(4)) u4 (
        .clk(clk), .rst(rst),
        .key_we(key_we4), .key_idx(key_idx4), .key_data(key_data4),
        .key_err(key_err4),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] key;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    vec_t        tab [7];
    logic [15:0] kk [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Forward round: rotate/add/xor, then key XOR.
    function automatic logic [15:0] enc_round(input logic [15:0] x,
                                              input logic [15:0] k);
        logic [7:0] hi, lo, th, tl;
        hi = x[15:8];
        lo = x[7:0];
        th = {hi[6:0], hi[7]} + lo;
        tl = {lo[5:0], lo[7:6]} ^ th;
        return {th, tl} ^ k;
    endfunction

    function automatic logic [15:0] enc4(input logic [15:0] p);
        logic [15:0] x;
        x = p;
        for (int i = 0; i < 4; i++)
            x = enc_round(x, kk[i]);
        return x;
    endfunction

    task automatic wr_key1(input logic idx, input logic [15:0] d);
        key_we1   = 1'b1;
        key_idx1  = idx;
        key_data1 = d;
        step();
        key_we1   = 1'b0;
    endtask

    task automatic wr_keys4();
        for (int i = 0; i < 4; i++) begin
            key_we4   = 1'b1;
            key_idx4  = 2'(i);
            key_data4 = kk[i];
            step();
        end
        key_we4 = 1'b0;
    endtask

    task automatic run1(input logic [15:0] d, output logic [15:0] got,
                        output int lat);
        in_valid1 = 1'b1;
        in_data1  = d;
        step();
        in_valid1 = 1'b0;
        lat = 1;
        while (!out_valid1 && lat < 20) begin
            step();
            lat++;
        end
        got = out_data1;
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
    endtask

    task automatic run4(input logic [15:0] c, input bit stall,
                        output logic [15:0] got, output int lat);
        int t;
        int ns;
        t = 0;
        while (!in_ready4 && t < 50) begin
            step();
            t++;
        end
        if (!in_ready4)
            check("run4_ready_timeout", 32'(in_ready4), 32'd1);
        in_valid4 = 1'b1;
        in_data4  = c;
        step();
        in_valid4 = 1'b0;
        lat = 1;
        while (!out_valid4 && lat < 50) begin
            step();
            lat++;
        end
        got = out_data4;
        ns  = stall ? int'($urandom_range(0, 2)) : 0;
        for (int i = 0; i < ns; i++) begin
            out_ready4 = 1'b0;
            step();
            check("stall_hold", {out_valid4, 15'd0, out_data4},
                  {1'b1, 15'd0, got});
        end
        out_ready4 = 1'b1;
        step();
        out_ready4 = 1'b0;
    endtask

    initial begin
        logic [15:0] got, p, c;
        logic [15:0] pt [10];
        logic [15:0] ct [10];
        int lat, nacc, nout, last;

        tab[0] = '{16'h0000, 16'h0100, 16'hE040};
        tab[1] = '{16'h0100, 16'h0000, 16'hE040};
        tab[2] = '{16'h0000, 16'h0000, 16'h0000};
        tab[3] = '{16'h0000, 16'h0001, 16'h6040};
        tab[4] = '{16'h0000, 16'hFFFF, 16'hFF00};
        tab[5] = '{16'h0000, 16'h8000, 16'h3020};
        tab[6] = '{16'h1234, 16'h1234, 16'h0000};

        rst = 1'b1;
        key_we1 = 0; key_idx1 = 0; key_data1 = 0;
        in_valid1 = 0; in_data1 = 0; out_ready1 = 0;
        key_we4 = 0; key_idx4 = 0; key_data4 = 0;
        in_valid4 = 0; in_data4 = 0; out_ready4 = 0;
        #2;
        check("rst_in_ready", {in_ready1, in_ready4}, 2'b11);
        check("rst_out_valid", {out_valid1, out_valid4}, 2'b00);
        check("rst_out_data", {out_data1, out_data4}, 32'd0);
        check("rst_key_err", {key_err1, key_err4}, 2'b00);
        step();
        rst = 1'b0;
        step();

        // NR=1 table
        foreach (tab[i]) begin
            wr_key1(1'b0, tab[i].key);
            run1(tab[i].din, got, lat);
            check($sformatf("tab%0d_data", i), got, tab[i].exp);
            check($sformatf("tab%0d_lat", i), lat, 1);
        end

        // NR=1: out-of-range index rejected, key unchanged
        wr_key1(1'b0, 16'h0000);
        wr_key1(1'b1, 16'hFFFF);
        check("nr1_idx_err", 32'(key_err1), 32'd1);
        step();
        check("nr1_err_pulse", 32'(key_err1), 32'd0);
        run1(16'h0100, got, lat);
        check("nr1_rk_kept", got, 16'hE040);

        // NR=1: key write coincident with accept uses old key
        key_we1 = 1'b1; key_idx1 = 1'b0; key_data1 = 16'h0100;
        in_valid1 = 1'b1; in_data1 = 16'h0100;
        step();
        key_we1 = 1'b0; in_valid1 = 1'b0;
        check("same_cyc_err", 32'(key_err1), 32'd0);
        check("same_cyc_old", {out_valid1, 15'd0, out_data1},
              {1'b1, 15'd0, 16'hE040});
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        run1(16'h0000, got, lat);
        check("same_cyc_new", got, 16'hE040);

        // NR=4 random round-trip
        for (int v = 0; v < 1000; v++) begin
            if (v % 100 == 0) begin
                for (int i = 0; i < 4; i++)
                    kk[i] = 16'($urandom);
                wr_keys4();
            end
            p = 16'($urandom);
            run4(enc4(p), 1'b1, got, lat);
            check($sformatf("rnd%0d_data", v), got, p);
            check($sformatf("rnd%0d_lat", v), lat, 4);
        end

        // key write during RUN dropped
        p = 16'hC0DE;
        in_valid4 = 1'b1;
        in_data4  = enc4(p);
        step();
        in_valid4 = 1'b0;
        key_we4 = 1'b1; key_idx4 = 2'd0; key_data4 = 16'hFFFF;
        step();
        key_we4 = 1'b0;
        check("run_key_err", 32'(key_err4), 32'd1);
        step();
        check("run_key_err_pulse", 32'(key_err4), 32'd0);
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            step();
            lat++;
        end
        check("run_key_cur", {out_valid4, 15'd0, out_data4},
              {1'b1, 15'd0, p});
        out_ready4 = 1'b1;
        step();
        out_ready4 = 1'b0;
        p = 16'h5A17;
        run4(enc4(p), 1'b0, got, lat);
        check("run_key_next", got, p);

        // back-to-back with in_valid held
        for (int i = 0; i < 10; i++) begin
            pt[i] = 16'(i * 16'h1357 + 16'h0A0B);
            ct[i] = enc4(pt[i]);
        end
        nacc = 0; nout = 0; last = -1;
        out_ready4 = 1'b1;
        in_valid4  = 1'b1;
        in_data4   = ct[0];
        for (int cyc = 0; cyc < 40; cyc++) begin
            bit acc;
            acc = in_ready4;
            if (out_valid4) begin
                check("b2b_ready_low", 32'(in_ready4), 32'd0);
                check($sformatf("b2b%0d_data", nout), out_data4, pt[nout]);
                nout++;
            end
            if (acc) begin
                if (last >= 0)
                    check("b2b_gap", cyc - last, 5);
                last = cyc;
                nacc++;
            end
            step();
            if (acc)
                in_data4 = ct[nacc];
        end
        in_valid4  = 1'b0;
        out_ready4 = 1'b0;
        check("b2b_acc_cnt", nacc, 8);
        check("b2b_out_cnt", nout, 8);

        // reset mid-RUN
        in_valid4 = 1'b1;
        in_data4  = 16'h1111;
        step();
        in_valid4 = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid4), 32'd0);
        check("mid_rst_ready", 32'(in_ready4), 32'd1);
        check("mid_rst_data", out_data4, 16'h0000);
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++)
            kk[i] = 16'h0000;
        p = 16'hBEEF;
        run4(enc4(p), 1'b0, got, lat);
        check("post_rst_zero_keys", got, p);
        check("post_rst_lat", lat, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
